// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the SAP control unit.
// Holds the opcode values, the bit positions of the control word and the
// sequencer state encoding. The state value is also the t_state output code.
// bus_drivers() picks out the five bus-enable bits of a control word.
package sap_ctrl_pkg;

   localparam int OPCODE_W_DEF = 4;
   localparam int CW_W_DEF     = 12;

   // Opcodes taken from IR[7:4]
   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Control word bit map {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
   localparam int CW_CP = 11;
   localparam int CW_EP = 10;
   localparam int CW_LM = 9;
   localparam int CW_CE = 8;
   localparam int CW_LI = 7;
   localparam int CW_EI = 6;
   localparam int CW_LA = 5;
   localparam int CW_EA = 4;
   localparam int CW_SU = 3;
   localparam int CW_EU = 2;
   localparam int CW_LB = 1;
   localparam int CW_LO = 0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_T3   = 3'd3,
      ST_T4   = 3'd4,
      ST_T5   = 3'd5,
      ST_T6   = 3'd6,
      ST_HALT = 3'd7
   } state_e;

   // Collects the bus drivers {Ep,CE,Ei,Ea,Eu}; at most one may be set
   function automatic logic [4:0] bus_drivers(input logic [CW_W_DEF-1:0] cw);
      return {cw[CW_EP], cw[CW_CE], cw[CW_EI], cw[CW_EA], cw[CW_EU]};
   endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// T-state sequencer for the SAP controller.
// Ports:
//   clk        in  rising-edge clock
//   clr_n      in  asynchronous active-low reset (forces IDLE)
//   run        in  start request, looked at only in IDLE
//   hlt_at_t4  in  current opcode is HLT; diverts T4 into HALT
//   state      out current state (IDLE, T1..T6, HALT)
module sap_ring_counter
   import sap_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   clr_n,
   input  logic   run,
   input  logic   hlt_at_t4,
   output state_e state
);

   state_e state_q;
   state_e state_d;

   // State register with asynchronous clear
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: free-running ring once started; HALT only leaves via clr_n
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_T1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_T1:   state_d = ST_T2;
         ST_T2:   state_d = ST_T3;
         ST_T3:   state_d = ST_T4;
         ST_T4: begin
            if (hlt_at_t4) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_T5;
            end
         end
         ST_T5:   state_d = ST_T6;
         ST_T6:   state_d = ST_T1;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   assign state = state_q;

endmodule

// File: rtl/sap_controller.sv
// SAP control/sequencer unit.
// Steps the T1..T6 ring and decodes the IR opcode into one control word
// per cycle for the SAP datapath.
// Ports:
//   clk        in  rising-edge clock
//   clr_n      in  asynchronous active-low reset
//   run        in  start request (sampled in IDLE only)
//   opcode     in  IR[7:4], stable from the end of T3
//   ctrl_word  out {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}; combinational
//   t_state    out 0=IDLE, 1..6=T1..T6, 7=HALT
//   halted     out high while in HALT
// The ALU select is Su: adder_subtractor.sum = ~Su, .cin = Su.
module sap_controller
   import sap_ctrl_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter int CW_W     = CW_W_DEF
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                run,
   input  logic [OPCODE_W-1:0] opcode,
   output logic [CW_W-1:0]     ctrl_word,
   output logic [2:0]          t_state,
   output logic                halted
);

   state_e          state_s;
   logic            hlt_s;
   logic [CW_W-1:0] ctrl_s;

   assign hlt_s = (opcode == OP_HLT);

   sap_ring_counter u_ring (
      .clk       (clk),
      .clr_n     (clr_n),
      .run       (run),
      .hlt_at_t4 (hlt_s),
      .state     (state_s)
   );

   // Control word decode; state drops to IDLE asynchronously so the word
   // clears the moment clr_n falls
   always_comb begin
      ctrl_s = '0;
      case (state_s)
         ST_T1: begin
            ctrl_s[CW_EP] = 1'b1;
            ctrl_s[CW_LM] = 1'b1;
         end
         ST_T2: begin
            ctrl_s[CW_CP] = 1'b1;
         end
         ST_T3: begin
            ctrl_s[CW_CE] = 1'b1;
            ctrl_s[CW_LI] = 1'b1;
         end
         ST_T4: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB: begin
                  ctrl_s[CW_EI] = 1'b1;
                  ctrl_s[CW_LM] = 1'b1;
               end
               OP_OUT: begin
                  ctrl_s[CW_EA] = 1'b1;
                  ctrl_s[CW_LO] = 1'b1;
               end
               default: ctrl_s = '0;
            endcase
         end
         ST_T5: begin
            case (opcode)
               OP_LDA: begin
                  ctrl_s[CW_CE] = 1'b1;
                  ctrl_s[CW_LA] = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl_s[CW_CE] = 1'b1;
                  ctrl_s[CW_LB] = 1'b1;
               end
               default: ctrl_s = '0;
            endcase
         end
         ST_T6: begin
            case (opcode)
               OP_ADD: begin
                  ctrl_s[CW_EU] = 1'b1;
                  ctrl_s[CW_LA] = 1'b1;
               end
               OP_SUB: begin
                  ctrl_s[CW_EU] = 1'b1;
                  ctrl_s[CW_LA] = 1'b1;
                  ctrl_s[CW_SU] = 1'b1;
               end
               default: ctrl_s = '0;
            endcase
         end
         default: ctrl_s = '0;
      endcase
   end

   assign ctrl_word = ctrl_s;
   assign t_state   = state_s;
   assign halted    = (state_s == ST_HALT);

   // Only one source may drive the shared bus in any cycle
   a_bus_exclusive: assert property (@(posedge clk) disable iff (!clr_n)
      $onehot0(bus_drivers(ctrl_s)));

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller.
// A small behavioural SAP datapath (PC, MAR, RAM, IR, A, B, OUT) is driven
// by the DUT's control word so that real programs execute; an
// instruction-level reference model predicts A/B/OUT, and a table of
// expected control words per opcode and T-state checks every cycle.
module tb_sap_controller;

   logic        clk;
   logic        clr_n;
   logic        run;
   logic [3:0]  opcode;
   logic [11:0] ctrl_word;
   logic [2:0]  t_state;
   logic        halted;

   int errors;
   int checks;

   // bench-side datapath
   logic [7:0] mem [16];
   logic [3:0] pc, mar;
   logic [7:0] ir, a_reg, b_reg, out_reg, bus;
   logic       use_dp;
   logic [3:0] op_drv;

   assign opcode = use_dp ? ir[7:4] : op_drv;

   sap_controller dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .run       (run),
      .opcode    (opcode),
      .ctrl_word (ctrl_word),
      .t_state   (t_state),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath reacting to {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         pc  <= 4'd0;
         mar <= 4'd0;
         ir  <= 8'd0;
      end else begin
         bus = 8'd0;
         if (ctrl_word[10]) bus = {4'd0, pc};
         if (ctrl_word[8])  bus = mem[mar];
         if (ctrl_word[6])  bus = {4'd0, ir[3:0]};
         if (ctrl_word[4])  bus = a_reg;
         if (ctrl_word[2])  bus = ctrl_word[3] ? (a_reg - b_reg) : (a_reg + b_reg);
         if (ctrl_word[11]) pc      <= pc + 4'd1;
         if (ctrl_word[9])  mar     <= bus[3:0];
         if (ctrl_word[7])  ir      <= bus;
         if (ctrl_word[5])  a_reg   <= bus;
         if (ctrl_word[1])  b_reg   <= bus;
         if (ctrl_word[0])  out_reg <= bus;
      end
   end

   // Expected control word for an opcode in T-state t (1..6)
   function automatic logic [11:0] exp_word(input logic [3:0] op, input int t);
      logic [11:0] fetch [3];
      fetch = '{12'h600, 12'h800, 12'h180};   // Ep|Lm, Cp, CE|Li
      if (t <= 3) return fetch[t-1];
      case (op)
         4'h0:    return (t == 4) ? 12'h240 : (t == 5) ? 12'h120 : 12'h000;
         4'h1:    return (t == 4) ? 12'h240 : (t == 5) ? 12'h102 : 12'h024;
         4'h2:    return (t == 4) ? 12'h240 : (t == 5) ? 12'h102 : 12'h02C;
         4'hE:    return (t == 4) ? 12'h011 : 12'h000;
         default: return 12'h000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one instruction from T1 (called at the negedge inside T1)
   task automatic run_instr(input logic [3:0] op, input bit garble);
      for (int t = 1; t <= 6; t++) begin
         if (!use_dp) begin
            op_drv = (garble && t <= 3) ? 4'($urandom_range(0, 15)) : op;
            if (garble) run = 1'($urandom_range(0, 1));
         end
         #1;
         chk($sformatf("cw op%0h T%0d", op, t), {4'd0, ctrl_word}, {4'd0, exp_word(op, t)});
         chk($sformatf("tstate op%0h T%0d", op, t), {13'd0, t_state}, 16'(t));
         chk("halted low", {15'd0, halted}, 16'd0);
         if (op == 4'hF && t == 4) begin
            @(negedge clk);
            chk("halt tstate", {13'd0, t_state}, 16'd7);
            chk("halt flag", {15'd0, halted}, 16'd1);
            chk("halt cw", {4'd0, ctrl_word}, 16'd0);
            return;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] ref_a, ref_b, ref_out, instr;
      errors = 0;
      checks = 0;
      clr_n  = 1'b0;
      run    = 1'b1;
      use_dp = 1'b1;
      op_drv = 4'h0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[0] = 8'h09;  // LDA 9
      mem[1] = 8'h1A;  // ADD 10
      mem[2] = 8'hE0;  // OUT
      mem[3] = 8'h09;  // LDA 9
      mem[4] = 8'h2A;  // SUB 10
      mem[5] = 8'h70;  // NOP
      mem[6] = 8'hE0;  // OUT
      mem[7] = 8'hF0;  // HLT
      mem[9]  = 8'd25;
      mem[10] = 8'd10;

      // reset held with run high
      repeat (3) begin
         @(negedge clk);
         chk("rst cw", {4'd0, ctrl_word}, 16'd0);
         chk("rst tstate", {13'd0, t_state}, 16'd0);
         chk("rst halted", {15'd0, halted}, 16'd0);
      end

      // program through the datapath
      clr_n = 1'b1;
      run   = 1'b1;
      @(negedge clk);
      run = 1'b0;
      ref_a = 8'd0; ref_b = 8'd0; ref_out = 8'd0;
      for (int k = 0; k < 8; k++) begin
         instr = mem[k];
         run_instr(instr[7:4], 1'b0);
         if (instr[7:4] == 4'hF) break;
         case (instr[7:4])
            4'h0: ref_a = mem[instr[3:0]];
            4'h1: begin ref_b = mem[instr[3:0]]; ref_a = ref_a + ref_b; end
            4'h2: begin ref_b = mem[instr[3:0]]; ref_a = ref_a - ref_b; end
            4'hE: ref_out = ref_a;
            default: ;
         endcase
         chk($sformatf("A after %0d", k), {8'd0, a_reg}, {8'd0, ref_a});
         if (instr[7:4] == 4'hE) chk($sformatf("OUT after %0d", k), {8'd0, out_reg}, {8'd0, ref_out});
      end
      chk("B final", {8'd0, b_reg}, {8'd0, ref_b});

      // HALT is sticky whatever run does
      repeat (20) begin
         run = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("hold tstate", {13'd0, t_state}, 16'd7);
         chk("hold halted", {15'd0, halted}, 16'd1);
         chk("hold cw", {4'd0, ctrl_word}, 16'd0);
      end

      // reset in the middle of ADD's T5
      mem[0]  = 8'h1A;
      mem[10] = 8'd77;
      clr_n = 1'b0;
      run   = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
      run   = 1'b1;
      @(negedge clk);
      run = 1'b0;
      for (int t = 1; t <= 4; t++) begin
         chk("pre-abort tstate", {13'd0, t_state}, 16'(t));
         @(negedge clk);
      end
      chk("abort T5 cw", {4'd0, ctrl_word}, 16'h102);
      #2 clr_n = 1'b0;
      #1;
      chk("abort cw", {4'd0, ctrl_word}, 16'd0);
      chk("abort tstate", {13'd0, t_state}, 16'd0);
      chk("abort halted", {15'd0, halted}, 16'd0);
      @(negedge clk);
      chk("abort B kept", {8'd0, b_reg}, {8'd0, ref_b});
      clr_n = 1'b1;
      run   = 1'b0;
      @(negedge clk);
      chk("idle after release", {13'd0, t_state}, 16'd0);

      // random opcodes, garbage on opcode during fetch, run toggling
      use_dp = 1'b0;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      for (int n = 0; n < 40; n++) begin
         run_instr(4'($urandom_range(0, 14)), 1'b1);
      end
      run_instr(4'hF, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
